// File: rtl/hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_if
// Bundle of pipeline status inputs and pipeline control outputs exchanged
// between the 5-stage datapath and the hazard controller.
//   master : the pipeline side (drives stage status, receives enables/flushes)
//   slave  : the hazard controller
// Inputs to the controller:
//   IF_ID_Rs_addr/IF_ID_Rt_addr/IF_ID_UseRt : sources of the ID instruction
//   ID_EX_Rt_addr/ID_EX_MemRead             : destination/load flag in EX
//   EX_Mem_Branch_taken                     : taken branch/jump resolved in MEM
//   MD_start                                : EX holds a multi-cycle mul/div
//   Mem_req/Mem_ready                       : MEM stage data access handshake
// Outputs of the controller:
//   PC_Write, IF_ID_Write, ID_EX_Write, EX_Mem_Write : register enables
//   IF_ID_Flush, ID_EX_Flush, EX_Mem_Flush           : bubble inserts
//   MD_done                                          : last mul/div cycle
//   Stall_count                                      : saturating stall counter
// -----------------------------------------------------------------------------
interface hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       IF_ID_Rs_addr;
    logic [4:0]       IF_ID_Rt_addr;
    logic             IF_ID_UseRt;
    logic [4:0]       ID_EX_Rt_addr;
    logic             ID_EX_MemRead;
    logic             EX_Mem_Branch_taken;
    logic             MD_start;
    logic             Mem_req;
    logic             Mem_ready;
    logic             PC_Write;
    logic             IF_ID_Write;
    logic             ID_EX_Write;
    logic             IF_ID_Flush;
    logic             ID_EX_Flush;
    logic             EX_Mem_Flush;
    logic             EX_Mem_Write;
    logic             MD_done;
    logic [CNT_W-1:0] Stall_count;

    modport master (
        output IF_ID_Rs_addr, IF_ID_Rt_addr, IF_ID_UseRt, ID_EX_Rt_addr,
               ID_EX_MemRead, EX_Mem_Branch_taken, MD_start, Mem_req, Mem_ready,
        input  PC_Write, IF_ID_Write, ID_EX_Write, IF_ID_Flush, ID_EX_Flush,
               EX_Mem_Flush, EX_Mem_Write, MD_done, Stall_count
    );

    modport slave (
        input  IF_ID_Rs_addr, IF_ID_Rt_addr, IF_ID_UseRt, ID_EX_Rt_addr,
               ID_EX_MemRead, EX_Mem_Branch_taken, MD_start, Mem_req, Mem_ready,
        output PC_Write, IF_ID_Write, ID_EX_Write, IF_ID_Flush, ID_EX_Flush,
               EX_Mem_Flush, EX_Mem_Write, MD_done, Stall_count
    );
endinterface

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// Pipeline hazard controller for a 5-stage pipeline. Resolves, in priority
// order, data-memory wait, multi-cycle mul/div occupancy of EX, taken-branch
// flush and load-use stall. Control outputs are combinational from the FSM
// state, the mul/div occupancy counter and the inputs; Stall_count is a
// registered saturating count of cycles with PC_Write low.
// Ports:
//   clk_i : clock, rising edge
//   rst_n : asynchronous active-low reset; while low, all enables are 0,
//           all flushes 1, MD_done 0
//   hz    : hazard_ctrl_if slave modport (see interface header)
// Parameters:
//   MD_LATENCY : EX occupancy of a mul/div in cycles (2..15)
//   CNT_W      : Stall_count width
// -----------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int MD_LATENCY = 4,
    parameter int CNT_W      = 16
) (
    input  logic         clk_i,
    input  logic         rst_n,
    hazard_ctrl_if.slave hz
);
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        MD_BUSY  = 2'd2
    } state_t;

    // The entry cycle (in RUN) is occupancy cycle 1 and consumes one count of
    // the MD_LATENCY-1 stall cycles, so MD_BUSY starts with one fewer.
    localparam logic [3:0] MD_LOAD = 4'(MD_LATENCY - 2);

    state_t           state_q, state_d;
    state_t           resume_q, resume_d;
    logic [3:0]       md_cnt_q, md_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic pc_w, ifid_w, idex_w, exmem_w;
    logic ifid_f, idex_f, exmem_f, md_done;
    logic mem_wait, load_use;

    assign mem_wait = hz.Mem_req && !hz.Mem_ready;

    // $0 is hard-wired zero, so a load into it never creates a dependency.
    assign load_use = hz.ID_EX_MemRead && (hz.ID_EX_Rt_addr != 5'd0) &&
                      ((hz.ID_EX_Rt_addr == hz.IF_ID_Rs_addr) ||
                       (hz.IF_ID_UseRt && (hz.ID_EX_Rt_addr == hz.IF_ID_Rt_addr)));

    always_comb begin
        state_d  = state_q;
        resume_d = resume_q;
        md_cnt_d = md_cnt_q;
        pc_w     = 1'b1;
        ifid_w   = 1'b1;
        idex_w   = 1'b1;
        exmem_w  = 1'b1;
        ifid_f   = 1'b0;
        idex_f   = 1'b0;
        exmem_f  = 1'b0;
        md_done  = 1'b0;

        if (state_q == MEM_WAIT) begin
            // The whole pipeline holds, including the cycle the access
            // completes; the interrupted state resumes on the next cycle
            // with md_cnt untouched.
            pc_w    = 1'b0;
            ifid_w  = 1'b0;
            idex_w  = 1'b0;
            exmem_w = 1'b0;
            if (!mem_wait) begin
                state_d = resume_q;
            end
        end else if (mem_wait) begin
            pc_w     = 1'b0;
            ifid_w   = 1'b0;
            idex_w   = 1'b0;
            exmem_w  = 1'b0;
            state_d  = MEM_WAIT;
            resume_d = (state_q == MD_BUSY) ? MD_BUSY : RUN;
        end else begin
            case (state_q)
                MD_BUSY: begin
                    // Front end holds; EX/MEM receives bubbles until the
                    // result is ready.
                    pc_w    = 1'b0;
                    ifid_w  = 1'b0;
                    idex_w  = 1'b0;
                    exmem_f = 1'b1;
                    if (md_cnt_q == 4'd1) begin
                        md_done  = 1'b1;
                        md_cnt_d = 4'd0;
                        state_d  = RUN;
                    end else begin
                        md_cnt_d = md_cnt_q - 4'd1;
                    end
                end
                RUN: begin
                    if (hz.EX_Mem_Branch_taken) begin
                        ifid_f  = 1'b1;
                        idex_f  = 1'b1;
                        exmem_f = 1'b1;
                    end else if (hz.MD_start) begin
                        pc_w    = 1'b0;
                        ifid_w  = 1'b0;
                        idex_w  = 1'b0;
                        exmem_f = 1'b1;
                        if (MD_LATENCY <= 2) begin
                            md_done = 1'b1;
                        end else begin
                            state_d  = MD_BUSY;
                            md_cnt_d = MD_LOAD;
                        end
                    end else if (load_use) begin
                        pc_w   = 1'b0;
                        ifid_w = 1'b0;
                        idex_f = 1'b1;
                    end
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end

        // Reset forces a safe, fully flushed pipeline without waiting for a clock.
        if (!rst_n) begin
            pc_w    = 1'b0;
            ifid_w  = 1'b0;
            idex_w  = 1'b0;
            exmem_w = 1'b0;
            ifid_f  = 1'b1;
            idex_f  = 1'b1;
            exmem_f = 1'b1;
            md_done = 1'b0;
        end

        stall_cnt_d = stall_cnt_q;
        if (!pc_w && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            resume_q    <= RUN;
            md_cnt_q    <= 4'd0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            resume_q    <= resume_d;
            md_cnt_q    <= md_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign hz.PC_Write     = pc_w;
    assign hz.IF_ID_Write  = ifid_w;
    assign hz.ID_EX_Write  = idex_w;
    assign hz.EX_Mem_Write = exmem_w;
    assign hz.IF_ID_Flush  = ifid_f;
    assign hz.ID_EX_Flush  = idex_f;
    assign hz.EX_Mem_Flush = exmem_f;
    assign hz.MD_done      = md_done;
    assign hz.Stall_count  = stall_cnt_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
// Directed bench for hazard_ctrl. Two instances share the same stimulus:
// dut16 (CNT_W=16) for function, dut4 (CNT_W=4) for counter saturation.
// Control outputs are packed as
//   {PC_Write, IF_ID_Write, ID_EX_Write, EX_Mem_Write,
//    IF_ID_Flush, ID_EX_Flush, EX_Mem_Flush, MD_done}
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;
    logic clk_i = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk_i = ~clk_i;

    logic [4:0] rs, rt, ex_rt;
    logic       use_rt, mem_read, br, md_start, mem_req, mem_ready;

    hazard_ctrl_if #(.CNT_W(16)) hz16 ();
    hazard_ctrl_if #(.CNT_W(4))  hz4 ();

    assign hz16.IF_ID_Rs_addr       = rs;
    assign hz16.IF_ID_Rt_addr       = rt;
    assign hz16.IF_ID_UseRt         = use_rt;
    assign hz16.ID_EX_Rt_addr       = ex_rt;
    assign hz16.ID_EX_MemRead       = mem_read;
    assign hz16.EX_Mem_Branch_taken = br;
    assign hz16.MD_start            = md_start;
    assign hz16.Mem_req             = mem_req;
    assign hz16.Mem_ready           = mem_ready;

    assign hz4.IF_ID_Rs_addr       = rs;
    assign hz4.IF_ID_Rt_addr       = rt;
    assign hz4.IF_ID_UseRt         = use_rt;
    assign hz4.ID_EX_Rt_addr       = ex_rt;
    assign hz4.ID_EX_MemRead       = mem_read;
    assign hz4.EX_Mem_Branch_taken = br;
    assign hz4.MD_start            = md_start;
    assign hz4.Mem_req             = mem_req;
    assign hz4.Mem_ready           = mem_ready;

    hazard_ctrl #(.MD_LATENCY(4), .CNT_W(16)) dut16 (
        .clk_i (clk_i),
        .rst_n (rst_n),
        .hz    (hz16)
    );

    hazard_ctrl #(.MD_LATENCY(4), .CNT_W(4)) dut4 (
        .clk_i (clk_i),
        .rst_n (rst_n),
        .hz    (hz4)
    );

    wire [7:0] ctl16 = {hz16.PC_Write, hz16.IF_ID_Write, hz16.ID_EX_Write, hz16.EX_Mem_Write,
                        hz16.IF_ID_Flush, hz16.ID_EX_Flush, hz16.EX_Mem_Flush, hz16.MD_done};
    wire [7:0] ctl4  = {hz4.PC_Write, hz4.IF_ID_Write, hz4.ID_EX_Write, hz4.EX_Mem_Write,
                        hz4.IF_ID_Flush, hz4.ID_EX_Flush, hz4.EX_Mem_Flush, hz4.MD_done};

    localparam logic [7:0] C_DEF  = 8'b1111_0000;
    localparam logic [7:0] C_RST  = 8'b0000_1110;
    localparam logic [7:0] C_MEMW = 8'b0000_0000;
    localparam logic [7:0] C_LU   = 8'b0011_0100;
    localparam logic [7:0] C_BR   = 8'b1111_1110;
    localparam logic [7:0] C_MD   = 8'b0001_0010;
    localparam logic [7:0] C_MDDN = 8'b0001_0011;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic clr_inputs();
        rs = 5'd0; rt = 5'd0; ex_rt = 5'd0;
        use_rt = 1'b0; mem_read = 1'b0; br = 1'b0;
        md_start = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    // Advance to just after the next rising edge; inputs change here.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        clr_inputs();
        rst_n = 1'b0;
        #2;
        n_checks++;
        if (ctl16 !== C_RST) $display("FAIL reset_ctl: got %b expected %b", ctl16, C_RST);
        else n_pass++;
        n_checks++;
        if (hz16.Stall_count !== 16'd0) $display("FAIL reset_cnt: got %0d expected 0", hz16.Stall_count);
        else n_pass++;
        step();
        step();
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (ctl16 !== C_DEF) $display("FAIL reset_release_ctl: got %b expected %b", ctl16, C_DEF);
        else n_pass++;
        step();
    endtask

    task automatic test_load_use();
        mem_read = 1'b1; ex_rt = 5'd5; rs = 5'd5; rt = 5'd7;
        #1;
        n_checks++;
        if (ctl16 !== C_LU) $display("FAIL lu_rs_ctl: got %b expected %b", ctl16, C_LU);
        else n_pass++;
        n_checks++;
        if (hz16.Stall_count !== 16'd0) $display("FAIL lu_rs_cnt_before: got %0d expected 0", hz16.Stall_count);
        else n_pass++;
        step();
        clr_inputs();
        #1;
        n_checks++;
        if (hz16.Stall_count !== 16'd1) $display("FAIL lu_rs_cnt_after: got %0d expected 1", hz16.Stall_count);
        else n_pass++;
        n_checks++;
        if (ctl16 !== C_DEF) $display("FAIL lu_rs_release: got %b expected %b", ctl16, C_DEF);
        else n_pass++;
        // Rt match with UseRt set stalls.
        mem_read = 1'b1; ex_rt = 5'd9; rs = 5'd3; rt = 5'd9; use_rt = 1'b1;
        #1;
        n_checks++;
        if (ctl16 !== C_LU) $display("FAIL lu_rt_ctl: got %b expected %b", ctl16, C_LU);
        else n_pass++;
        step();
        // Rt match without UseRt does not.
        use_rt = 1'b0;
        #1;
        n_checks++;
        if (ctl16 !== C_DEF) $display("FAIL lu_rt_nouse: got %b expected %b", ctl16, C_DEF);
        else n_pass++;
        step();
        clr_inputs();
        #1;
        n_checks++;
        if (hz16.Stall_count !== 16'd2) $display("FAIL lu_cnt_total: got %0d expected 2", hz16.Stall_count);
        else n_pass++;
    endtask

    task automatic test_zero_reg();
        mem_read = 1'b1; ex_rt = 5'd0; rs = 5'd0; rt = 5'd0; use_rt = 1'b1;
        #1;
        n_checks++;
        if (ctl16 !== C_DEF) $display("FAIL zero_reg_ctl: got %b expected %b", ctl16, C_DEF);
        else n_pass++;
        step();
        clr_inputs();
        #1;
        n_checks++;
        if (hz16.Stall_count !== 16'd2) $display("FAIL zero_reg_cnt: got %0d expected 2", hz16.Stall_count);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        mem_read = 1'b1; ex_rt = 5'd12; rs = 5'd12;
        #1;
        n_checks++;
        if (ctl16 !== C_LU) $display("FAIL b2b_first: got %b expected %b", ctl16, C_LU);
        else n_pass++;
        step();
        ex_rt = 5'd13; rs = 5'd1; rt = 5'd13; use_rt = 1'b1;
        #1;
        n_checks++;
        if (ctl16 !== C_LU) $display("FAIL b2b_second: got %b expected %b", ctl16, C_LU);
        else n_pass++;
        step();
        clr_inputs();
        #1;
        n_checks++;
        if (hz16.Stall_count !== 16'd4) $display("FAIL b2b_cnt: got %0d expected 4", hz16.Stall_count);
        else n_pass++;
    endtask

    task automatic test_md();
        logic [7:0] exp_seq [3];
        exp_seq[0] = C_MD; exp_seq[1] = C_MD; exp_seq[2] = C_MDDN;
        md_start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if (ctl16 !== exp_seq[i]) $display("FAIL md_cycle%0d: got %b expected %b", i + 1, ctl16, exp_seq[i]);
            else n_pass++;
            step();
            md_start = 1'b0;
        end
        #1;
        n_checks++;
        if (ctl16 !== C_DEF) $display("FAIL md_result_advance: got %b expected %b", ctl16, C_DEF);
        else n_pass++;
        n_checks++;
        if (hz16.Stall_count !== 16'd7) $display("FAIL md_cnt16: got %0d expected 7", hz16.Stall_count);
        else n_pass++;
        n_checks++;
        if (hz4.Stall_count !== 4'd7) $display("FAIL md_cnt4: got %0d expected 7", hz4.Stall_count);
        else n_pass++;
        step();
    endtask

    task automatic test_branch_priority();
        br = 1'b1; md_start = 1'b1; mem_read = 1'b1; ex_rt = 5'd4; rs = 5'd4;
        #1;
        n_checks++;
        if (ctl16 !== C_BR) $display("FAIL br_ctl: got %b expected %b", ctl16, C_BR);
        else n_pass++;
        step();
        clr_inputs();
        #1;
        n_checks++;
        if (ctl16 !== C_DEF) $display("FAIL br_no_md: got %b expected %b", ctl16, C_DEF);
        else n_pass++;
        n_checks++;
        if (hz16.Stall_count !== 16'd7) $display("FAIL br_cnt: got %0d expected 7", hz16.Stall_count);
        else n_pass++;
    endtask

    task automatic test_mem_wait_run();
        mem_req = 1'b1; mem_ready = 1'b0;
        // A taken branch during a memory wait loses to the wait.
        br = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_checks++;
            if (ctl16 !== C_MEMW) $display("FAIL memw_run_%0d: got %b expected %b", i, ctl16, C_MEMW);
            else n_pass++;
            step();
        end
        br = 1'b0;
        mem_ready = 1'b1;
        #1;
        n_checks++;
        if (ctl16 !== C_MEMW) $display("FAIL memw_run_ready: got %b expected %b", ctl16, C_MEMW);
        else n_pass++;
        step();
        clr_inputs();
        #1;
        n_checks++;
        if (ctl16 !== C_DEF) $display("FAIL memw_run_resume: got %b expected %b", ctl16, C_DEF);
        else n_pass++;
        n_checks++;
        if (hz16.Stall_count !== 16'd10) $display("FAIL memw_run_cnt: got %0d expected 10", hz16.Stall_count);
        else n_pass++;
    endtask

    task automatic test_mem_wait_md();
        md_start = 1'b1;
        #1;
        n_checks++;
        if (ctl16 !== C_MD) $display("FAIL memw_md_entry: got %b expected %b", ctl16, C_MD);
        else n_pass++;
        step();
        md_start = 1'b0;
        mem_req = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_checks++;
            if (ctl16 !== C_MEMW) $display("FAIL memw_md_hold%0d: got %b expected %b", i, ctl16, C_MEMW);
            else n_pass++;
            step();
        end
        mem_ready = 1'b1;
        #1;
        n_checks++;
        if (ctl16 !== C_MEMW) $display("FAIL memw_md_ready: got %b expected %b", ctl16, C_MEMW);
        else n_pass++;
        step();
        clr_inputs();
        #1;
        n_checks++;
        if (ctl16 !== C_MD) $display("FAIL memw_md_resume: got %b expected %b", ctl16, C_MD);
        else n_pass++;
        step();
        #1;
        n_checks++;
        if (ctl16 !== C_MDDN) $display("FAIL memw_md_done: got %b expected %b", ctl16, C_MDDN);
        else n_pass++;
        step();
        #1;
        n_checks++;
        if (ctl16 !== C_DEF) $display("FAIL memw_md_after: got %b expected %b", ctl16, C_DEF);
        else n_pass++;
        n_checks++;
        if (hz16.Stall_count !== 16'd19) $display("FAIL memw_md_cnt16: got %0d expected 19", hz16.Stall_count);
        else n_pass++;
    endtask

    task automatic test_saturation();
        n_checks++;
        if (hz4.Stall_count !== 4'd15) $display("FAIL sat_reached: got %0d expected 15", hz4.Stall_count);
        else n_pass++;
        mem_read = 1'b1; ex_rt = 5'd20; rs = 5'd20;
        #1;
        n_checks++;
        if (ctl4 !== C_LU) $display("FAIL sat_ctl4: got %b expected %b", ctl4, C_LU);
        else n_pass++;
        step();
        clr_inputs();
        #1;
        n_checks++;
        if (hz4.Stall_count !== 4'd15) $display("FAIL sat_hold: got %0d expected 15", hz4.Stall_count);
        else n_pass++;
        n_checks++;
        if (hz16.Stall_count !== 16'd20) $display("FAIL sat_cnt16: got %0d expected 20", hz16.Stall_count);
        else n_pass++;
    endtask

    task automatic test_reset_mid_md();
        md_start = 1'b1;
        step();
        md_start = 1'b0;
        #1;
        n_checks++;
        if (ctl16 !== C_MD) $display("FAIL rst_md_busy: got %b expected %b", ctl16, C_MD);
        else n_pass++;
        // Asynchronous assertion away from any clock edge.
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (ctl16 !== C_RST) $display("FAIL rst_md_async_ctl: got %b expected %b", ctl16, C_RST);
        else n_pass++;
        n_checks++;
        if (hz16.Stall_count !== 16'd0) $display("FAIL rst_md_cnt16: got %0d expected 0", hz16.Stall_count);
        else n_pass++;
        n_checks++;
        if (hz4.Stall_count !== 4'd0) $display("FAIL rst_md_cnt4: got %0d expected 0", hz4.Stall_count);
        else n_pass++;
        step();
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (ctl16 !== C_DEF) $display("FAIL rst_md_release: got %b expected %b", ctl16, C_DEF);
        else n_pass++;
        step();
        #1;
        n_checks++;
        if (ctl16 !== C_DEF) $display("FAIL rst_md_run: got %b expected %b", ctl16, C_DEF);
        else n_pass++;
        n_checks++;
        if (hz16.Stall_count !== 16'd0) $display("FAIL rst_md_cnt_after: got %0d expected 0", hz16.Stall_count);
        else n_pass++;
    endtask

    task automatic test_reset_mid_mem();
        mem_req = 1'b1; mem_ready = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (ctl16 !== C_RST) $display("FAIL rst_mem_ctl: got %b expected %b", ctl16, C_RST);
        else n_pass++;
        step();
        clr_inputs();
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (ctl16 !== C_DEF) $display("FAIL rst_mem_release: got %b expected %b", ctl16, C_DEF);
        else n_pass++;
        step();
        #1;
        n_checks++;
        if (ctl16 !== C_DEF) $display("FAIL rst_mem_run: got %b expected %b", ctl16, C_DEF);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_zero_reg();
        test_back_to_back();
        test_md();
        test_branch_priority();
        test_mem_wait_run();
        test_mem_wait_md();
        test_saturation();
        test_reset_mid_md();
        test_reset_mid_mem();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
